matrix_array_sequencer: RTL and testbench

Controller that sequences one N×N systolic matrix array through a full matrix-vector batch. It loads N weight rows from the weight buffer, then streams M activation vectors from the unified buffer with per-row diagonal skew. It drives the array's `weight_ctr`, `systolic_ctr` and `FMA_ctr` enables and de-skews the array's column results into aligned output rows. It sits between the buffer read ports and the array, and the accumulator writes `out_data` at `out_idx`.

---
 rtl/matrix_array_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_matrix_array_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_array_sequencer.sv
// Sequencer for one NxN systolic array: weight load, skewed
// activation streaming, enable generation and result de-skew.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, vec_count      batch request and vector count M
//   busy, done            batch in progress / completion pulse
//   wt_rd_en/addr/data    weight buffer read (1-cycle latency)
//   act_rd_en/addr/data   activation buffer read (1-cycle latency)
//   weight_ctr            array weight-shift enable
//   systolic_ctr, FMA_ctr array forward / FMA enables
//   weight_input          weight row to the array top edge
//   systolic_input        skewed activations to the left edge
//   result                bottom-row FMA outputs of the array
//   out_valid/data/idx    aligned result row and its vector index
module matrix_array_sequencer #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [7:0]     vec_count,
  output logic           busy,
  output logic           done,
  output logic           wt_rd_en,
  output logic [7:0]     wt_rd_addr,
  input  logic [8*N-1:0] wt_rd_data,
  output logic           act_rd_en,
  output logic [7:0]     act_rd_addr,
  input  logic [8*N-1:0] act_rd_data,
  output logic           weight_ctr,
  output logic           systolic_ctr,
  output logic           FMA_ctr,
  output logic [8*N-1:0] weight_input,
  output logic [8*N-1:0] systolic_input,
  input  logic [8*N-1:0] result,
  output logic           out_valid,
  output logic [8*N-1:0] out_data,
  output logic [7:0]     out_idx
);

  localparam int VL = 2 * N - 1;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic [7:0]      m;
  logic [7:0]      idx_q;
  logic [8:0]      en_cnt;
  logic            ctr_q;
  logic            act_valid;
  logic [VL-1:0]   vld_sr;
  logic [8*N-1:0]  aligned;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      m           <= '0;
      idx_q       <= '0;
      en_cnt      <= '0;
      ctr_q       <= 1'b0;
      act_valid   <= 1'b0;
      vld_sr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wt_rd_en    <= 1'b0;
      wt_rd_addr  <= '0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      weight_ctr  <= 1'b0;
    end else begin
      weight_ctr <= wt_rd_en;
      act_valid  <= act_rd_en;
      // out_valid trails the first skewed lane by 2N-1 cycles
      vld_sr     <= {vld_sr[VL-2:0], act_valid};
      if (out_valid)
        idx_q <= idx_q + 8'd1;
      // enable window length M+2N-2, counted down from M+2N-3
      if (ctr_q) begin
        if (en_cnt == 9'd0)
          ctr_q <= 1'b0;
        else
          en_cnt <= en_cnt - 9'd1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= WLOAD;
            m          <= vec_count;
            busy       <= 1'b1;
            wt_rd_en   <= 1'b1;
            wt_rd_addr <= 8'(N - 1);
            cnt        <= '0;
            idx_q      <= '0;
          end
        end
        WLOAD: begin
          if (cnt == 8'(N - 1)) begin
            wt_rd_en   <= 1'b0;
            wt_rd_addr <= '0;
            cnt        <= '0;
            if (m != 8'd0) begin
              state       <= COMPUTE;
              act_rd_en   <= 1'b1;
              act_rd_addr <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt        <= cnt + 8'd1;
            wt_rd_addr <= wt_rd_addr - 8'd1;
          end
        end
        COMPUTE: begin
          if (cnt == 8'd0) begin
            ctr_q  <= 1'b1;
            en_cnt <= {1'b0, m} + 9'(2 * N - 3);
          end
          if (cnt == m - 8'd1) begin
            act_rd_en   <= 1'b0;
            act_rd_addr <= '0;
            cnt         <= '0;
            state       <= DRAIN;
          end else begin
            cnt         <= cnt + 8'd1;
            act_rd_addr <= act_rd_addr + 8'd1;
          end
        end
        DRAIN: begin
          if (out_valid && idx_q == m - 8'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign systolic_ctr = ctr_q;
  assign FMA_ctr      = ctr_q;
  assign out_valid    = vld_sr[VL-1];
  assign out_idx      = out_valid ? idx_q : 8'd0;
  assign out_data     = out_valid ? aligned : '0;
  assign weight_input = weight_ctr ? wt_rd_data : '0;

  assign systolic_input[7:0] =
    act_valid ? act_rd_data[7:0] : 8'd0;

  // lane i of the activation vector is delayed i cycles
  for (genvar i = 1; i < N; i++) begin : g_skew
    logic [7:0] sr [0:i-1];
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int k = 0; k < i; k++)
          sr[k] <= 8'd0;
      end else begin
        sr[0] <= act_valid ? act_rd_data[8*i +: 8] : 8'd0;
        for (int k = 1; k < i; k++)
          sr[k] <= sr[k-1];
      end
    end
    assign systolic_input[8*i +: 8] = sr[i-1];
  end

  // column j arrives j cycles late; pad it to N-1 total
  assign aligned[8*(N-1) +: 8] = result[8*(N-1) +: 8];

  for (genvar j = 0; j < N - 1; j++) begin : g_deskew
    localparam int D = N - 1 - j;
    logic [7:0] dr [0:D-1];
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int k = 0; k < D; k++)
          dr[k] <= 8'd0;
      end else begin
        dr[0] <= result[8*j +: 8];
        for (int k = 1; k < D; k++)
          dr[k] <= dr[k-1];
      end
    end
    assign aligned[8*j +: 8] = dr[D-1];
  end

endmodule

// File: tb/tb_matrix_array_sequencer.sv
// Bench for matrix_array_sequencer: buffer and array models,
// timeline/scoreboard reference checked every cycle.
module tb_matrix_array_sequencer;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   vec_count = 8'd0;
  logic         busy, done;
  logic         wt_rd_en, act_rd_en;
  logic [7:0]   wt_rd_addr, act_rd_addr;
  logic [W-1:0] wt_rd_data = '0;
  logic [W-1:0] act_rd_data = '0;
  logic         weight_ctr, systolic_ctr, FMA_ctr;
  logic [W-1:0] weight_input, systolic_input;
  logic [W-1:0] result = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [7:0]   out_idx;

  always #5 clk = ~clk;

  matrix_array_sequencer #(.N(N)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .vec_count(vec_count),
    .busy(busy),
    .done(done),
    .wt_rd_en(wt_rd_en),
    .wt_rd_addr(wt_rd_addr),
    .wt_rd_data(wt_rd_data),
    .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr),
    .act_rd_data(act_rd_data),
    .weight_ctr(weight_ctr),
    .systolic_ctr(systolic_ctr),
    .FMA_ctr(FMA_ctr),
    .weight_input(weight_input),
    .systolic_input(systolic_input),
    .result(result),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_idx(out_idx)
  );

  logic [W-1:0] wmem [N];
  logic [W-1:0] amem [256];
  logic [W-1:0] expv [256];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // buffers: 1-cycle read latency, junk when not reading
  always @(posedge clk) begin
    wt_rd_data  <= wt_rd_en ? wmem[wt_rd_addr[1:0]]
                            : W'($urandom);
    act_rd_data <= act_rd_en ? amem[act_rd_addr]
                             : W'($urandom);
  end

  // array model: weights shift down on weight_ctr; result
  // for vector k, column j after k+N+j enabled edges
  bit           clr_hist = 1'b0;
  logic [W-1:0] wa [N];
  logic [W-1:0] hist [$];

  always @(posedge clk) begin : arr
    int p, k, acc;
    logic [W-1:0] rn, hv;
    if (clr_hist) hist.delete();
    if (weight_ctr) begin
      for (int r = N - 1; r > 0; r--) wa[r] = wa[r-1];
      wa[0] = weight_input;
    end
    if (systolic_ctr) begin
      hist.push_back(systolic_input);
      p  = hist.size();
      rn = '0;
      for (int j = 0; j < N; j++) begin
        k   = p - N - j;
        acc = 0;
        if (k >= 0)
          for (int i = 0; i < N; i++) begin
            hv  = hist[k+i];
            acc += int'(hv[8*i +: 8]) * int'(wa[i][8*j +: 8]);
          end
        rn[8*j +: 8] = acc[7:0];
      end
      result <= rn;
    end
  end

  int   total = 0;
  int   bad = 0;
  bit   mact = 1'b0;
  int   s0 = 0;
  int   mm = 0;
  int   done_rel, ov_first, wctr_n, sctr_n, aen_n;
  logic [W-1:0] obs [$];
  logic [7:0]   waddr_log [$];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               nm, a, e, cyc);
    end
  endtask

  function automatic logic [W-1:0] obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return 'x;
  endfunction

  task automatic cmp_cycle();
    int r, dr, k;
    logic [31:0] eb, ed, ewe, ewa, ewc, ewi, eae, eaa;
    logic [31:0] ec, es, eov, eix, eod;
    logic [W-1:0] av;
    eb = 0; ed = 0; ewe = 0; ewa = 0; ewc = 0; ewi = 0;
    eae = 0; eaa = 0; ec = 0; es = 0; eov = 0; eix = 0;
    eod = 0;
    if (mact) begin
      r   = cyc - s0;
      dr  = (mm > 0) ? 3 * N + mm + 1 : N + 1;
      eb  = 32'(r >= 1 && r <= dr);
      ed  = 32'(r == dr);
      ewe = 32'(r >= 1 && r <= N);
      if (ewe != 0) ewa = 32'(N - r);
      ewc = 32'(r >= 2 && r <= N + 1);
      if (ewc != 0) ewi = wmem[N+1-r];
      eae = 32'(mm > 0 && r >= N + 1 && r <= N + mm);
      if (eae != 0) eaa = 32'(r - N - 1);
      ec  = 32'(mm > 0 && r >= N + 2 && r <= 3 * N + mm - 1);
      for (int i = 0; i < N; i++) begin
        k = r - N - 2 - i;
        if (mm > 0 && k >= 0 && k < mm) begin
          av = amem[k];
          es[8*i +: 8] = av[8*i +: 8];
        end
      end
      eov = 32'(mm > 0 && r >= 3 * N + 1 && r <= 3 * N + mm);
      if (eov != 0) begin
        eix = 32'(r - 3 * N - 1);
        eod = expv[eix];
      end
    end
    chk("busy", 32'(busy), eb);
    chk("done", 32'(done), ed);
    chk("wt_rd_en", 32'(wt_rd_en), ewe);
    chk("wt_rd_addr", 32'(wt_rd_addr), ewa);
    chk("weight_ctr", 32'(weight_ctr), ewc);
    chk("weight_input", weight_input, ewi);
    chk("act_rd_en", 32'(act_rd_en), eae);
    chk("act_rd_addr", 32'(act_rd_addr), eaa);
    chk("systolic_ctr", 32'(systolic_ctr), ec);
    chk("FMA_ctr", 32'(FMA_ctr), ec);
    chk("systolic_input", systolic_input, es);
    chk("out_valid", 32'(out_valid), eov);
    chk("out_idx", 32'(out_idx), eix);
    chk("out_data", out_data, eod);
    if (out_valid) obs.push_back(out_data);
    if (out_valid && ov_first < 0) ov_first = cyc - s0;
    if (done) done_rel = cyc - s0;
    if (wt_rd_en) waddr_log.push_back(wt_rd_addr);
    if (weight_ctr) wctr_n++;
    if (systolic_ctr) sctr_n++;
    if (act_rd_en) aen_n++;
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_batch(input int m);
    logic [W-1:0] av, wv;
    int acc;
    for (int k = 0; k < m; k++) begin
      av = amem[k];
      expv[k] = '0;
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int i = 0; i < N; i++) begin
          wv  = wmem[i];
          acc += int'(av[8*i +: 8]) * int'(wv[8*j +: 8]);
        end
        expv[k][8*j +: 8] = acc[7:0];
      end
    end
    obs.delete();
    waddr_log.delete();
    wctr_n = 0; sctr_n = 0; aen_n = 0;
    done_rel = -1; ov_first = -1;
    start = 1'b1;
    vec_count = 8'(m);
    clr_hist = 1'b1;
    s0 = cyc; mact = 1'b1; mm = m;
    tick();
    start = 1'b0;
    clr_hist = 1'b0;
    vec_count = 8'($urandom);
  endtask

  task automatic run_batch(input int m, input bit poke);
    int dr;
    dr = (m > 0) ? 3 * N + m + 1 : N + 1;
    begin_batch(m);
    if (poke) begin
      start = 1'b1;
      vec_count = 8'd7;
      tick();
      start = 1'b0;
      repeat (dr - 1) tick();
    end else begin
      repeat (dr) tick();
    end
  endtask

  task automatic set_ident();
    for (int i = 0; i < N; i++) wmem[i] = W'(1) << (8 * i);
  endtask

  initial begin
    logic [31:0] wv;
    int m;
    for (int i = 0; i < N; i++) begin
      wmem[i] = '0;
      wa[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      amem[i] = '0;
      expv[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_wt_rd_en", 32'(wt_rd_en), 0);
    tick();

    set_ident();
    amem[0] = 32'h04030201;
    run_batch(1, 1'b0);
    chk("id_row", obs_at(0), 32'h04030201);
    chk("id_rows", 32'(obs.size()), 1);
    chk("id_ov_at", 32'(ov_first), 13);
    chk("id_done_at", 32'(done_rel), 14);

    for (int i = 0; i < N; i++)
      wmem[i] = 32'h01010101 * (32'h10 + 32'(i));
    amem[0] = $urandom;
    amem[1] = $urandom;
    run_batch(2, 1'b0);
    wv = (waddr_log.size() == 4) ?
         {waddr_log[0], waddr_log[1],
          waddr_log[2], waddr_log[3]} : 'x;
    chk("wo_addr_seq", wv, 32'h03020100);
    chk("wo_wctr_n", 32'(wctr_n), 4);

    for (int i = 0; i < N; i++) wmem[i] = 32'h01010101;
    amem[0] = 32'h01010101;
    amem[1] = 32'h00000002;
    amem[2] = 32'h05000000;
    run_batch(3, 1'b0);
    chk("m3_row0", obs_at(0), 32'h04040404);
    chk("m3_row1", obs_at(1), 32'h02020202);
    chk("m3_row2", obs_at(2), 32'h05050505);
    chk("m3_ov_at", 32'(ov_first), 13);
    chk("m3_en_n", 32'(sctr_n), 9);

    run_batch(0, 1'b1);
    chk("m0_rows", 32'(obs.size()), 0);
    chk("m0_act_n", 32'(aen_n), 0);
    chk("m0_done_at", 32'(done_rel), 5);

    for (int i = 0; i < N; i++) wmem[i] = $urandom;
    for (int i = 0; i < 5; i++) amem[i] = $urandom;
    begin_batch(5);
    repeat (N + 2) tick();
    reset_n = 1'b0;
    tick();
    mact = 1'b0;
    reset_n = 1'b1;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_sys_in", systolic_input, 0);
    chk("ab_ctr", 32'(systolic_ctr), 0);
    repeat (3) tick();
    set_ident();
    amem[0] = 32'h08070605;
    run_batch(1, 1'b0);
    chk("ab_next_row", obs_at(0), 32'h08070605);
    chk("ab_next_done", 32'(done_rel), 14);

    for (int i = 0; i < N; i++) wmem[i] = 32'hFFFFFFFF;
    amem[0] = 32'h000000FF;
    run_batch(1, 1'b0);
    chk("ovf_row", obs_at(0), 32'h01010101);

    for (int t = 0; t < 8; t++) begin
      m = $urandom_range(0, 12);
      for (int i = 0; i < N; i++) wmem[i] = $urandom;
      for (int i = 0; i < m; i++) amem[i] = $urandom;
      run_batch(m, 1'($urandom_range(0, 1)));
      chk("rnd_rows", 32'(obs.size()), 32'(m));
    end
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
